// File: rtl/cnn_pkg.sv
// Shared constants and FSM state encoding for the first-layer OFM window reader.
package cnn_pkg;

   localparam int BYTE_W     = 8;
   localparam int WORD_BYTES = 4;
   localparam int WORD_W     = BYTE_W * WORD_BYTES;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_PRESENT = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/ofm_window_pos_counter.sv
// Window position counter: column innermost, row outer; wraps to (0,0) after the last window.
module ofm_window_pos_counter #(
   parameter int MAP_ROWS  = 43,
   parameter int ROW_WORDS = 4,
   parameter int WIN       = 4,
   parameter int ADDR_W    = $clog2(MAP_ROWS * ROW_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_advance,
   output logic [ADDR_W-1:0] o_row,
   output logic [ADDR_W-1:0] o_col,
   output logic              o_last
);

   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(MAP_ROWS - WIN);
   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(ROW_WORDS - 1);

   logic [ADDR_W-1:0] r_row;
   logic [ADDR_W-1:0] r_col;
   logic              w_col_wrap;

   assign w_col_wrap = (r_col == LAST_COL);
   assign o_last     = w_col_wrap && (r_row == LAST_ROW);
   assign o_row      = r_row;
   assign o_col      = r_col;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clear) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_advance) begin
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= o_last ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ofm_window_reader.sv
// Scans the stored OFM maps as WIN-row x one-word windows, reading all channels in
// parallel and presenting each window on a valid/ready handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for start; no memory traffic
// ST_READ    | issuing WIN row addresses on consecutive cycles
// ST_WAIT    | last row's data returning from the synchronous memory
// ST_PRESENT | window held on outputs until win_ready
// ST_DONE    | one-cycle done pulse, then back to idle
module ofm_window_reader
   import cnn_pkg::*;
#(
   parameter int N         = 2,
   parameter int MAP_ROWS  = 43,
   parameter int ROW_WORDS = 4,
   parameter int WIN       = 4,
   parameter int ADDR_W    = $clog2(MAP_ROWS * ROW_WORDS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      mem_rd_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [N*WORD_W-1:0]       mem_rdata,
   output logic                      win_valid,
   input  logic                      win_ready,
   output logic [N*WIN*WORD_W-1:0]   win_data,
   output logic [ADDR_W-1:0]         win_row,
   output logic [ADDR_W-1:0]         win_col,
   output logic                      win_last
);

   localparam int IDX_W = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int AW1   = ADDR_W + 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIN - 1);
   localparam logic [ADDR_W:0]  ADDR_MAX = AW1'(MAP_ROWS * ROW_WORDS - 1);

   state_t               r_state;
   state_t               w_next;
   logic [IDX_W-1:0]     r_rd_idx;
   logic [IDX_W-1:0]     r_cap_idx;
   logic                 r_cap_vld;
   logic [N*WIN*WORD_W-1:0] r_win_data;
   logic                 w_last;
   logic                 w_handshake;
   logic                 w_start_ok;
   logic [ADDR_W:0]      w_addr_wide;

   assign w_start_ok  = (r_state == ST_IDLE) && start;
   assign w_handshake = (r_state == ST_PRESENT) && win_ready;

   ofm_window_pos_counter #(
      .MAP_ROWS  (MAP_ROWS),
      .ROW_WORDS (ROW_WORDS),
      .WIN       (WIN),
      .ADDR_W    (ADDR_W)
   ) u_pos (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_start_ok),
      .i_advance (w_handshake),
      .o_row     (win_row),
      .o_col     (win_col),
      .o_last    (w_last)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (start) w_next = ST_READ;
         ST_READ:    if (r_rd_idx == IDX_LAST) w_next = ST_WAIT;
         ST_WAIT:    w_next = ST_PRESENT;
         ST_PRESENT: if (win_ready) w_next = w_last ? ST_DONE : ST_READ;
         ST_DONE:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_rd_idx  <= '0;
         r_cap_idx <= '0;
         r_cap_vld <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_rd_idx  <= (r_state == ST_READ) ? r_rd_idx + 1'b1 : '0;
         r_cap_vld <= mem_rd_en;
         r_cap_idx <= r_rd_idx;
      end
   end

   // Read data lands one cycle after its address, so capture uses the delayed row index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win_data <= '0;
      end else if (r_cap_vld) begin
         for (int ch = 0; ch < N; ch++) begin
            r_win_data[(ch*WIN + int'(r_cap_idx))*WORD_W +: WORD_W] <= mem_rdata[ch*WORD_W +: WORD_W];
         end
      end
   end

   assign w_addr_wide = ({1'b0, win_row} + AW1'(r_rd_idx)) * AW1'(ROW_WORDS) + {1'b0, win_col};

   assign mem_rd_en = (r_state == ST_READ);
   assign mem_addr  = !mem_rd_en ? '0 :
                      (w_addr_wide > ADDR_MAX) ? ADDR_MAX[ADDR_W-1:0] : w_addr_wide[ADDR_W-1:0];
   assign busy      = (r_state == ST_READ) || (r_state == ST_WAIT) || (r_state == ST_PRESENT);
   assign done      = (r_state == ST_DONE);
   assign win_valid = (r_state == ST_PRESENT);
   assign win_last  = (r_state == ST_PRESENT) && w_last;
   assign win_data  = r_win_data;

endmodule
